// File: rtl/ecg_sign_packer.sv
// ecg_sign_packer: gathers the sign bits of nonzero samples from every ECG of a
// block and hands one LSB-aligned packed sign field plus its bit count to the
// bitstream packer over a registered valid/ready output.
module ecg_sign_packer #(
  parameter int unsigned J       = 10,
  parameter int unsigned N       = 4,
  parameter int unsigned NUM_ECG = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [N*J-1:0]                     in_samples,
  input  logic [$clog2(NUM_ECG)-1:0]         in_ecgidx,
  input  logic                               in_group_skip,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [N*(NUM_ECG-1)-1:0]           out_sign_bits,
  output logic [$clog2(N*(NUM_ECG-1)+1)-1:0] out_size,
  output logic                               seq_err
);

  localparam int unsigned IW = $clog2(NUM_ECG);
  localparam int unsigned SW = N * (NUM_ECG - 1);
  localparam int unsigned CW = $clog2(SW + 1);
  localparam int unsigned KW = $clog2(N + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_ECG - 1);

  logic [SW-1:0] acc;
  logic [CW-1:0] acc_size;
  logic [IW-1:0] expected;
  logic [N-1:0]  grp_bits;
  logic [KW-1:0] grp_cnt;
  logic          accept;
  logic          in_sync;
  logic          is_last;

  // A new group may enter whenever the output slot is free or being drained.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign in_sync  = (in_ecgidx == expected);
  assign is_last  = (in_ecgidx == LAST_IDX);

  // Compact the signs of nonzero samples, sample 0 ending up most significant.
  always_comb begin
    grp_bits = '0;
    grp_cnt  = '0;
    if (!(in_group_skip || is_last)) begin
      for (int k = 0; k < int'(N); k++) begin
        if (|in_samples[k*J +: J]) begin
          grp_bits = (grp_bits << 1) | N'(in_samples[k*J + J - 1]);
          grp_cnt  = grp_cnt + KW'(1);
        end
      end
    end
  end

  // Block accumulation, completion, output hand-off and sequence checking.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_sign_bits <= '0;
      out_size      <= '0;
      seq_err       <= 1'b0;
      acc           <= '0;
      acc_size      <= '0;
      expected      <= '0;
    end else begin
      seq_err <= 1'b0;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        if (in_sync) begin
          if (is_last) begin
            // Last group contributes no signs; publish and start a new block.
            out_sign_bits <= acc;
            out_size      <= acc_size;
            out_valid     <= 1'b1;
            acc           <= '0;
            acc_size      <= '0;
            expected      <= '0;
          end else begin
            acc      <= (acc << grp_cnt) | SW'(grp_bits);
            acc_size <= acc_size + CW'(grp_cnt);
            expected <= expected + IW'(1);
          end
        end else begin
          // Abort the partial block; an index-0 group restarts a fresh one.
          seq_err <= 1'b1;
          if (in_ecgidx == '0) begin
            acc      <= SW'(grp_bits);
            acc_size <= CW'(grp_cnt);
            expected <= IW'(1);
          end else begin
            acc      <= '0;
            acc_size <= '0;
            expected <= '0;
          end
        end
      end
    end
  end

endmodule
